imem_loader: RTL

Writes a program image into the processor's instruction memory from a byte stream, ahead of execution. Assembles big-endian 16-bit instruction words (opcode in bits [15:13], the field the control unit decodes) and issues one write per word to instruction memory. Holds the CPU with `cpu_hold` for the whole load, then reports completion or a length error. It is the writer side of the instruction memory, which the fetch/decode path reads.

---
 rtl/imem_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction memory loader: turns a length-prefixed big-endian byte stream into
// one instruction-memory write per 16-bit word while holding the CPU off.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for load_start; CPU runs
// LEN_HI  | accept upper byte of the word count
// LEN_LO  | accept lower byte of the word count, then range-check it
// WORD_HI | accept upper byte of the next instruction
// WORD_LO | accept lower byte of the next instruction
// WRITE   | one-cycle memory write strobe, advance pointer and counters
// DONE    | one-cycle completion pulse
// ERR     | one-cycle length-error pulse; rest of the stream is left unread
module imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_start,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               imem_wr_en,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wr_data,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err,
    output logic [ADDR_W:0]    word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_WORD_HI,
        S_WORD_LO,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] CAP = 17'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic              byte_ready_q, byte_ready_d;
    logic              wr_en_q, wr_en_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [15:0]       len_full;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        remain_d = remain_q;
        count_d  = count_q;
        len_d    = len_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        // byte_ready_q mirrors "current state is a byte state"
        accept   = byte_valid && byte_ready_q;
        len_full = {len_q[15:8], byte_data};

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d  = S_LEN_HI;
                    ptr_d    = '0;
                    remain_d = '0;
                    count_d  = '0;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = byte_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = byte_data;
                    if (len_full == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, len_full} > CAP) begin
                        state_d = S_ERR;
                    end else begin
                        state_d  = S_WORD_HI;
                        remain_d = len_full[ADDR_W:0];
                    end
                end
            end
            S_WORD_HI: begin
                if (accept) begin
                    hi_d    = byte_data;
                    state_d = S_WORD_LO;
                end
            end
            S_WORD_LO: begin
                if (accept) begin
                    lo_d    = byte_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // pointer wraps naturally on a full-capacity load
                ptr_d    = ptr_q + ADDR_W'(1);
                count_d  = count_q + (ADDR_W + 1)'(1);
                remain_d = remain_q - (ADDR_W + 1)'(1);
                state_d  = (remain_q == (ADDR_W + 1)'(1)) ? S_DONE : S_WORD_HI;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        byte_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                       (state_d == S_WORD_HI) || (state_d == S_WORD_LO);
        wr_en_d      = (state_d == S_WRITE);
        hold_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        err_d        = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            remain_q     <= '0;
            count_q      <= '0;
            len_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            hold_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            remain_q     <= remain_d;
            count_q      <= count_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign imem_wr_en   = wr_en_q;
    assign imem_addr    = ptr_q;
    assign imem_wr_data = {hi_q, lo_q};
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign word_count   = count_q;

endmodule
